tx_iq_fifo_dac: RTL and testbench

//  IQ buffer between the OFDM TX core output (result_i/q/iq_valid) and the DAC sample interface.

---
 rtl/tx_iq_fifo_dac.sv | 204 ++++++++++++++++++++
 tb/tb_tx_iq_fifo_dac.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_iq_fifo_dac.sv
// IQ FIFO between the OFDM TX core and the DAC: prefill, stream on sample_strobe, drain after done.
// Optional build macro TX_IQ_GAIN_EN adds a Q2.6 gain stage (one extra output register).
module tx_iq_fifo_dac #(
   parameter int DEPTH_LOG2 = 9,
   parameter int IQ_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  result_iq_valid,
   input  logic [IQ_W-1:0]       result_i,
   input  logic [IQ_W-1:0]       result_q,
   output logic                  result_iq_hold,
   input  logic                  phy_tx_done,
   input  logic                  sample_strobe,
   input  logic [DEPTH_LOG2:0]   prefill_level,
   input  logic [DEPTH_LOG2:0]   hold_thresh,
`ifdef TX_IQ_GAIN_EN
   input  logic [7:0]            gain,
`endif
   output logic [IQ_W-1:0]       dac_i,
   output logic [IQ_W-1:0]       dac_q,
   output logic                  dac_valid,
   output logic                  tx_active,
   output logic                  buf_done,
   output logic                  overflow,
   output logic                  underrun,
   output logic [DEPTH_LOG2:0]   fifo_fill
);

   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_STREAM, S_TAIL} state_t;
   state_t state_q, state_d;

   logic [2*IQ_W-1:0] mem_q [0:DEPTH-1];
   logic [2*IQ_W-1:0] rd_data;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q, fill, fill_next, prefill_eff;
   logic              full, empty, push, pop;
   logic              done_q, done_d, ovf_q, ovf_d, unr_q, unr_d, hold_q;
   logic              out_upd, out_vld, out_done;
   logic [IQ_W-1:0]   out_i, out_q;
   logic [IQ_W-1:0]   dac_i_q, dac_q_q;
   logic              dac_valid_q, buf_done_q;

   assign fill        = wr_ptr_q - rd_ptr_q;
   assign full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
   assign empty       = (wr_ptr_q == rd_ptr_q);
   assign push        = result_iq_valid && !full;
   assign pop         = sample_strobe && !empty &&
                        ((state_q == S_STREAM) || (state_q == S_TAIL));
   assign fill_next   = fill + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};
   assign prefill_eff = (prefill_level == '0) ? {{(PW-1){1'b0}}, 1'b1} : prefill_level;
   assign rd_data     = mem_q[rd_ptr_q[PW-2:0]];

   always_comb begin
      state_d  = state_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      unr_d    = unr_q;
      out_upd  = 1'b0;
      out_vld  = 1'b0;
      out_done = 1'b0;
      out_i    = '0;
      out_q    = '0;
      if (result_iq_valid && full) ovf_d = 1'b1;
      if ((state_q != S_IDLE) && phy_tx_done) done_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (push) begin
               state_d = S_PREFILL;
               ovf_d   = 1'b0;
               unr_d   = 1'b0;
               done_d  = phy_tx_done;
            end
         end
         S_PREFILL: begin
            if ((fill >= prefill_eff) || done_q) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (done_q) state_d = S_TAIL;
            // an empty strobe still emits a (zero) sample so the DAC cadence never slips
            if (sample_strobe) begin
               out_upd = 1'b1;
               out_vld = 1'b1;
               if (!empty) {out_i, out_q} = rd_data;
               else        unr_d = 1'b1;
            end
         end
         S_TAIL: begin
            if (sample_strobe) begin
               out_upd = 1'b1;
               if (!empty) begin
                  out_vld        = 1'b1;
                  {out_i, out_q} = rd_data;
               end else begin
                  state_d  = S_IDLE;
                  out_done = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unr_q    <= 1'b0;
         hold_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, push};
         rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, pop};
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         unr_q    <= unr_d;
         hold_q   <= (fill_next >= hold_thresh);
      end
   end

   // storage needs no reset: pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PW-2:0]] <= {result_i, result_q};
   end

`ifdef TX_IQ_GAIN_EN
   function automatic logic [IQ_W-1:0] apply_gain(input logic [IQ_W-1:0] x, input logic [7:0] g);
      logic signed [IQ_W+8:0] xs, gs, prod;
      xs   = (IQ_W+9)'($signed(x));
      gs   = {{(IQ_W+1){1'b0}}, g};
      prod = (xs * gs) >>> 6;
      if ((prod[IQ_W+8:IQ_W-1] == '0) || (prod[IQ_W+8:IQ_W-1] == '1))
         return prod[IQ_W-1:0];
      else if (prod[IQ_W+8])
         return {1'b1, {(IQ_W-1){1'b0}}};
      else
         return {1'b0, {(IQ_W-1){1'b1}}};
   endfunction

   logic            s1_upd_q, s1_vld_q, s1_done_q;
   logic [IQ_W-1:0] s1_i_q, s1_q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_upd_q    <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_done_q   <= 1'b0;
         s1_i_q      <= '0;
         s1_q_q      <= '0;
         dac_i_q     <= '0;
         dac_q_q     <= '0;
         dac_valid_q <= 1'b0;
         buf_done_q  <= 1'b0;
      end else begin
         s1_upd_q    <= out_upd;
         s1_vld_q    <= out_vld;
         s1_done_q   <= out_done;
         if (out_upd) begin
            s1_i_q <= out_i;
            s1_q_q <= out_q;
         end
         if (s1_upd_q) begin
            dac_i_q <= apply_gain(s1_i_q, gain);
            dac_q_q <= apply_gain(s1_q_q, gain);
         end
         dac_valid_q <= s1_vld_q;
         buf_done_q  <= s1_done_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         dac_i_q     <= '0;
         dac_q_q     <= '0;
         dac_valid_q <= 1'b0;
         buf_done_q  <= 1'b0;
      end else begin
         if (out_upd) begin
            dac_i_q <= out_i;
            dac_q_q <= out_q;
         end
         dac_valid_q <= out_vld;
         buf_done_q  <= out_done;
      end
   end
`endif

   assign result_iq_hold = hold_q;
   assign dac_i          = dac_i_q;
   assign dac_q          = dac_q_q;
   assign dac_valid      = dac_valid_q;
   assign buf_done       = buf_done_q;
   assign tx_active      = (state_q != S_IDLE);
   assign overflow       = ovf_q;
   assign underrun       = unr_q;
   assign fifo_fill      = fill;

endmodule

// File: tb/tb_tx_iq_fifo_dac.sv
// Bench for tx_iq_fifo_dac: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations and randomized packets.
module tb_tx_iq_fifo_dac;
   localparam int DL    = 4;
   localparam int W     = 16;
   localparam int DEPTH = 1 << DL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          result_iq_valid = 1'b0;
   logic [W-1:0]  result_i = '0, result_q = '0;
   logic          result_iq_hold;
   logic          phy_tx_done = 1'b0;
   logic          sample_strobe = 1'b0;
   logic [DL:0]   prefill_level = 5'd8, hold_thresh = 5'd12;
   logic [7:0]    gain = 8'h40;
   logic [W-1:0]  dac_i, dac_q;
   logic          dac_valid, tx_active, buf_done, overflow, underrun;
   logic [DL:0]   fifo_fill;

   tx_iq_fifo_dac #(.DEPTH_LOG2(DL), .IQ_W(W)) dut (
      .clk(clk), .rst(rst),
      .result_iq_valid(result_iq_valid), .result_i(result_i), .result_q(result_q),
      .result_iq_hold(result_iq_hold), .phy_tx_done(phy_tx_done),
      .sample_strobe(sample_strobe), .prefill_level(prefill_level), .hold_thresh(hold_thresh),
`ifdef TX_IQ_GAIN_EN
      .gain(gain),
`endif
      .dac_i(dac_i), .dac_q(dac_q), .dac_valid(dac_valid), .tx_active(tx_active),
      .buf_done(buf_done), .overflow(overflow), .underrun(underrun), .fifo_fill(fifo_fill)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] gsat(input logic [15:0] x, input logic [7:0] g);
      int p;
      p = ($signed(x) * int'(g)) >>> 6;
      if (p > 32767)  return 16'h7fff;
      if (p < -32768) return 16'h8000;
      return 16'(p);
   endfunction

   // ---------------- reference model: sample queue + packet phase ----------------
   logic [31:0] mq[$];
   int          mmode = 0;          // 0 idle, 1 prefill, 2 stream, 3 tail
   bit          mdl = 0, movf = 0, munr = 0, mhold = 0, mv = 0, mb = 0, mu = 0;
   logic [15:0] mi = '0, mqq = '0;
   logic [15:0] gi = '0, gq = '0;
   bit          gv = 0, gb = 0;

   always @(posedge clk) begin : model
      int pre, nmode, pf;
      logic [31:0] s;
      logic [15:0] o_i, o_q;
      bit o_v, o_b, o_u;
      if (rst) begin
         mq.delete(); mmode = 0; mdl = 0; movf = 0; munr = 0; mhold = 0;
         mi = '0; mqq = '0; mv = 0; mb = 0; mu = 0; gi = '0; gq = '0; gv = 0; gb = 0;
      end else begin
         pre = mq.size(); o_i = mi; o_q = mqq; o_v = mv; o_b = mb; o_u = mu;
         mv = 0; mb = 0; mu = 0; nmode = mmode;
         if ((mmode == 2 || mmode == 3) && sample_strobe) begin
            mu = 1;
            if (pre > 0) begin
               s = mq.pop_front(); mi = s[31:16]; mqq = s[15:0]; mv = 1;
            end else begin
               mi = '0; mqq = '0;
               if (mmode == 2) begin mv = 1; munr = 1; end
               else begin mb = 1; nmode = 0; end
            end
         end
         if (result_iq_valid) begin
            if (pre == DEPTH) movf = 1;
            else mq.push_back({result_i, result_q});
         end
         pf = (prefill_level == 0) ? 1 : int'(prefill_level);
         case (mmode)
            0: if (result_iq_valid) begin nmode = 1; movf = 0; munr = 0; mdl = phy_tx_done; end
            1: if (pre >= pf || mdl) nmode = 2;
            2: if (mdl) nmode = 3;
            default: ;
         endcase
         if (mmode != 0 && phy_tx_done) mdl = 1;
         mmode = nmode;
         mhold = (mq.size() >= int'(hold_thresh));
         if (o_u) begin gi = gsat(o_i, gain); gq = gsat(o_q, gain); end
         gv = o_v; gb = o_b;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [15:0] ei, eq;
      bit ev, eb;
`ifdef TX_IQ_GAIN_EN
      ei = gi; eq = gq; ev = gv; eb = gb;
`else
      ei = mi; eq = mqq; ev = mv; eb = mb;
`endif
      if (chk_en) begin
         chk("hold",      32'(result_iq_hold), 32'(mhold));
         chk("dac_i",     32'(dac_i),          32'(ei));
         chk("dac_q",     32'(dac_q),          32'(eq));
         chk("dac_valid", 32'(dac_valid),      32'(ev));
         chk("buf_done",  32'(buf_done),       32'(eb));
         chk("tx_active", 32'(tx_active),      32'(mmode != 0));
         chk("overflow",  32'(overflow),       32'(movf));
         chk("underrun",  32'(underrun),       32'(munr));
         chk("fifo_fill", 32'(fifo_fill),      32'(mq.size()));
      end
   end

   // ---------------- output monitor for literal checks ----------------
   logic [31:0] obs[$];
   int n_valid = 0, n_bdone = 0, maxf = 0;
   bit seen_v = 0;
   always @(negedge clk) begin
      if (!seen_v && int'(fifo_fill) > maxf) maxf = int'(fifo_fill);
      if (dac_valid) begin obs.push_back({dac_i, dac_q}); n_valid++; seen_v = 1; end
      if (buf_done) n_bdone++;
   end

   int cnt = 0, strobe_period = 0;
   task automatic cyc();
      @(posedge clk); #2;
      cnt++;
      if (strobe_period != 0) sample_strobe = (cnt % strobe_period == 0);
   endtask

   task automatic clr_mon();
      obs.delete(); n_valid = 0; n_bdone = 0; maxf = 0; seen_v = 0;
   endtask

   task automatic push_samp(input logic [15:0] i, input logic [15:0] q);
      result_iq_valid = 1'b1; result_i = i; result_q = q; cyc(); result_iq_valid = 1'b0;
   endtask

   task automatic pulse_done();
      phy_tx_done = 1'b1; cyc(); phy_tx_done = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int k = 0;
      while (tx_active && k < maxc) begin cyc(); k++; end
      chk("drain_timeout", 32'(tx_active), 32'd0);
   endtask

   logic [31:0] sent[$];

   initial begin
      int zc;
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int zc, n, sentc, k;
      bit respect, same, midrst, go;
      // reset state
      rst = 1'b1; cyc(); chk_en = 1'b1; cyc();
      chk("rst_fill", 32'(fifo_fill), 0); chk("rst_active", 32'(tx_active), 0);
      chk("rst_hold", 32'(result_iq_hold), 0); chk("rst_valid", 32'(dac_valid), 0);
      rst = 1'b0; cyc();

      // 1: prefill 8, strobe every 5, samples 1..12
      clr_mon(); prefill_level = 5'd8; hold_thresh = 5'd12; strobe_period = 5;
      for (int k2 = 1; k2 <= 12; k2++) begin
         result_iq_valid = 1'b1; result_i = 16'(k2); result_q = 16'(16'h100 + k2); cyc();
      end
      result_iq_valid = 1'b0;
      pulse_done();
      wait_idle(300); cyc();
      chk("t1_nvalid", 32'(n_valid), 12);
      for (int k2 = 0; k2 < 12 && k2 < obs.size(); k2++)
         chk("t1_order", obs[k2], {16'(k2 + 1), 16'(16'h101 + k2)});
      chk("t1_prefill_reached", 32'(maxf >= 8), 1);
      chk("t1_bdone", 32'(n_bdone), 1);
      chk("t1_underrun", 32'(underrun), 0);

      // 2: hold and overflow with no strobes, 20 back-to-back pushes
      clr_mon(); sent.delete(); strobe_period = 0; sample_strobe = 1'b0;
      for (int k2 = 0; k2 < 20; k2++) begin
         result_iq_valid = 1'b1; result_i = 16'($urandom); result_q = 16'($urandom);
         sent.push_back({result_i, result_q}); cyc();
      end
      result_iq_valid = 1'b0; cyc();
      chk("t2_fill", 32'(fifo_fill), 16); chk("t2_ovf", 32'(overflow), 1);
      chk("t2_hold", 32'(result_iq_hold), 1);
      pulse_done(); strobe_period = 3;
      wait_idle(300); cyc();
      chk("t2_nvalid", 32'(n_valid), 16);
      for (int k2 = 0; k2 < 16 && k2 < obs.size(); k2++) chk("t2_order", obs[k2], sent[k2]);

      // 3: core stalls during STREAM -> zero samples and sticky underrun
      clr_mon(); prefill_level = 5'd4; strobe_period = 4;
      for (int k2 = 0; k2 < 4; k2++) push_samp(16'(k2 + 1), 16'(k2 + 7));
      repeat (40) cyc();
      chk("t3_unr", 32'(underrun), 1);
      zc = 0;
      foreach (obs[j]) if (obs[j] == 32'd0) zc++;
      chk("t3_zero_pulses", 32'(zc >= 3), 1);
      push_samp(16'h55, 16'h66); push_samp(16'h77, 16'h88); pulse_done();
      wait_idle(300); cyc();
      chk("t3_unr_sticky", 32'(underrun), 1);

      // 4: push+pop at full and at fill 5
      strobe_period = 0; sample_strobe = 1'b0; prefill_level = 5'd8;
      push_samp(16'h1, 16'h1);
      chk("t4_unr_clr", 32'(underrun), 0);
      for (int k2 = 0; k2 < 15; k2++) push_samp(16'(k2 + 2), 16'(k2));
      cyc();
      chk("t4_full", 32'(fifo_fill), 16);
      result_iq_valid = 1'b1; sample_strobe = 1'b1; cyc();
      result_iq_valid = 1'b0; sample_strobe = 1'b0;
      chk("t4_fill15", 32'(fifo_fill), 15); chk("t4_ovf", 32'(overflow), 1);
      repeat (10) begin sample_strobe = 1'b1; cyc(); sample_strobe = 1'b0; cyc(); end
      chk("t4_fill5", 32'(fifo_fill), 5);
      result_iq_valid = 1'b1; sample_strobe = 1'b1; cyc();
      result_iq_valid = 1'b0; sample_strobe = 1'b0;
      chk("t4_fill5_pp", 32'(fifo_fill), 5);

      // 5: reset mid-STREAM with fill 9
      for (int k2 = 0; k2 < 4; k2++) push_samp(16'h9, 16'h9);
      chk("t5_fill9", 32'(fifo_fill), 9);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("t5_fill", 32'(fifo_fill), 0); chk("t5_hold", 32'(result_iq_hold), 0);
      chk("t5_dac", {dac_i, dac_q}, 0); chk("t5_active", 32'(tx_active), 0);
      chk("t5_flags", {30'd0, overflow, underrun}, 0);
      clr_mon(); prefill_level = 5'd2; strobe_period = 2;
      push_samp(16'hA, 16'hB); push_samp(16'hC, 16'hD); push_samp(16'hE, 16'hF); pulse_done();
      wait_idle(200); cyc();
      chk("t5_nvalid", 32'(n_valid), 3);

`ifdef TX_IQ_GAIN_EN
      // 6: gain 2.0 with saturation
      clr_mon(); gain = 8'h80; prefill_level = 5'd3; strobe_period = 4;
      push_samp(16'h3000, 16'h0001); push_samp(16'h5000, 16'h0002); push_samp(16'hA000, 16'h0003);
      pulse_done(); wait_idle(200); repeat (2) cyc();
      chk("t6_n", 32'(obs.size()), 3);
      if (obs.size() == 3) begin
         chk("t6_a", 32'(obs[0][31:16]), 32'h6000);
         chk("t6_b", 32'(obs[1][31:16]), 32'h7fff);
         chk("t6_c", 32'(obs[2][31:16]), 32'h8000);
      end
`endif

      // random packets
      for (int p = 0; p < 25; p++) begin
`ifdef TX_IQ_GAIN_EN
         gain = 8'($urandom);
`endif
         hold_thresh   = 5'($urandom_range(4, 12));
         prefill_level = 5'($urandom_range(0, 20));
         strobe_period = $urandom_range(2, 6);
         respect = ($urandom_range(0, 3) != 0);
         if (respect && prefill_level > hold_thresh) prefill_level = hold_thresh;
         same = $urandom_range(0, 1); midrst = ($urandom_range(0, 7) == 0);
         n = $urandom_range(1, 40); sentc = 0; k = 0;
         while (sentc < n && k < 400) begin
            go = ($urandom_range(0, 3) != 0) && !(respect && result_iq_hold);
            result_iq_valid = go; result_i = 16'($urandom); result_q = 16'($urandom);
            phy_tx_done = go && same && (sentc == n - 1);
            if (go) sentc++;
            cyc(); k++;
         end
         result_iq_valid = 1'b0; phy_tx_done = 1'b0;
         if (!same) pulse_done();
         if (midrst) begin rst = 1'b1; cyc(); rst = 1'b0; end
         else wait_idle(1500);
         repeat (3) cyc();
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
